// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: register-file write port, fetch request/controls, and the
// operand result handshake. The slave side is the fetch unit; the master side is
// whoever issues fetches, writes registers and consumes operands.
interface operand_fetch_if;
    // register-file write port
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    // fetch request and per-fetch controls
    logic        start;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [15:0] sximm5;
    // result handshake
    logic        ack;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic        valid;
    logic        busy;

    modport master (
        output write, writenum, data_in,
        output start, readnum_a, readnum_b, shift, asel, bsel, sximm5,
        output ack,
        input  Ain, Bin, valid, busy
    );

    modport slave (
        input  write, writenum, data_in,
        input  start, readnum_a, readnum_b, shift, asel, bsel, sximm5,
        input  ack,
        output Ain, Bin, valid, busy
    );
endinterface

// File: rtl/operand_fetch.sv
// Purpose: 8x16 register file plus a 4-state fetch sequencer presenting ALU operands Ain/Bin.
// Latency: start sampled on the IDLE edge, valid rises after the third fetch edge (IDLE->LOAD_A->LOAD_B->ISSUE).
// Backpressure: ISSUE holds valid and Ain/Bin until ack; start outside IDLE is dropped, writes always accepted.
module operand_fetch (
    input  logic           clk,
    input  logic           reset,
    operand_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    state_t      state;
    logic [15:0] regfile [8];

    logic [15:0] reg_a;
    logic [15:0] reg_b;
    logic [2:0]  readnum_b_q;
    logic [1:0]  shift_q;
    logic        asel_q;
    logic        bsel_q;
    logic [15:0] sximm5_q;
    logic        valid_q;
    logic        busy_q;

    logic [15:0] shifted_b;

    // Register file: single synchronous write port, open in every state; reads
    // elsewhere see the pre-edge contents, so a same-edge write is not forwarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                regfile[i] <= 16'h0000;
            end
        end else if (bus.write) begin
            regfile[bus.writenum] <= bus.data_in;
        end
    end

    // Fetch sequencer: latches controls and A on accept, loads B, spends one
    // settle cycle, then holds the result in ISSUE until the consumer acks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            reg_a       <= 16'h0000;
            reg_b       <= 16'h0000;
            readnum_b_q <= 3'd0;
            shift_q     <= SH_NONE;
            asel_q      <= 1'b0;
            bsel_q      <= 1'b0;
            sximm5_q    <= 16'h0000;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        readnum_b_q <= bus.readnum_b;
                        shift_q     <= bus.shift;
                        asel_q      <= bus.asel;
                        bsel_q      <= bus.bsel;
                        sximm5_q    <= bus.sximm5;
                        reg_a       <= regfile[bus.readnum_a];
                        busy_q      <= 1'b1;
                        state       <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    reg_b <= regfile[readnum_b_q];
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    valid_q <= 1'b1;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Single-bit shifter on B; shifted-out bits are dropped, ASR keeps the sign.
    always_comb begin
        shifted_b = reg_b;
        case (shift_q)
            SH_NONE: shifted_b = reg_b;
            SH_LSL1: shifted_b = {reg_b[14:0], 1'b0};
            SH_LSR1: shifted_b = {1'b0, reg_b[15:1]};
            SH_ASR1: shifted_b = {reg_b[15], reg_b[15:1]};
            default: shifted_b = reg_b;
        endcase
    end

    // Operand muxing is purely combinational from the held registers, so the
    // outputs are stable for as long as the sequencer sits in ISSUE.
    assign bus.Ain   = asel_q ? 16'h0000 : reg_a;
    assign bus.Bin   = bsel_q ? sximm5_q : shifted_b;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic clk;
    logic reset;
    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int passed;

    typedef struct {
        logic [2:0]  a;
        logic [2:0]  b;
        logic [1:0]  sh;
        logic        asel;
        logic        bsel;
        logic [15:0] imm;
        logic [15:0] exp_ain;
        logic [15:0] exp_bin;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [15:0] val);
        @(negedge clk);
        bus.write    = 1'b1;
        bus.writenum = idx;
        bus.data_in  = val;
        @(negedge clk);
        bus.write    = 1'b0;
    endtask

    // Call at a negedge; drives start and the fetch controls for the next edge.
    task automatic set_fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                             input logic as, input logic bs, input logic [15:0] imm);
        bus.start     = 1'b1;
        bus.readnum_a = a;
        bus.readnum_b = b;
        bus.shift     = sh;
        bus.asel      = as;
        bus.bsel      = bs;
        bus.sximm5    = imm;
    endtask

    // Steps three edges after set_fetch and checks valid timing; ends at the
    // negedge where the sequencer should be in ISSUE.
    task automatic wait_valid(input string tag, input logic keep_start);
        @(negedge clk);
        bus.start = keep_start;
        bus.write = 1'b0;
        chk({tag, ".busy_la"}, {15'd0, bus.busy}, 16'd1);
        chk({tag, ".valid_la"}, {15'd0, bus.valid}, 16'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, ".valid_lb"}, {15'd0, bus.valid}, 16'd0);
        @(negedge clk);
        chk({tag, ".valid_is"}, {15'd0, bus.valid}, 16'd1);
    endtask

    task automatic do_ack(input string tag);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        chk({tag, ".valid_off"}, {15'd0, bus.valid}, 16'd0);
        chk({tag, ".busy_off"}, {15'd0, bus.busy}, 16'd0);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        bus.write = 0; bus.writenum = 0; bus.data_in = 0;
        bus.start = 0; bus.readnum_a = 0; bus.readnum_b = 0; bus.shift = 0;
        bus.asel = 0; bus.bsel = 0; bus.sximm5 = 0; bus.ack = 0;

        vecs[0] = '{3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000, 16'hF0CF, 16'hB965};
        vecs[1] = '{3'd1, 3'd2, 2'b11, 1'b0, 1'b0, 16'h0000, 16'hF0CF, 16'hDCB2};
        vecs[2] = '{3'd1, 3'd2, 2'b01, 1'b0, 1'b0, 16'h0000, 16'hF0CF, 16'h72CA};
        vecs[3] = '{3'd1, 3'd2, 2'b10, 1'b0, 1'b0, 16'h0000, 16'hF0CF, 16'h5CB2};
        vecs[4] = '{3'd2, 3'd4, 2'b11, 1'b0, 1'b0, 16'h0000, 16'hB965, 16'hC000};
        vecs[5] = '{3'd4, 3'd4, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h8001, 16'h0002};
        vecs[6] = '{3'd5, 3'd5, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h7FFF, 16'h3FFF};
        vecs[7] = '{3'd5, 3'd5, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h7FFF, 16'h3FFF};
        vecs[8] = '{3'd1, 3'd2, 2'b11, 1'b1, 1'b1, 16'hFFF0, 16'h0000, 16'hFFF0};
        vecs[9] = '{3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hF0CF};

        // reset state, asynchronous
        reset = 1'b0;
        #1;
        chk("rst.valid", {15'd0, bus.valid}, 16'd0);
        chk("rst.busy", {15'd0, bus.busy}, 16'd0);
        chk("rst.Ain", bus.Ain, 16'h0000);
        chk("rst.Bin", bus.Bin, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // same-edge write and read of R3 returns the old value
        @(negedge clk);
        set_fetch(3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0000);
        bus.write = 1'b1; bus.writenum = 3'd3; bus.data_in = 16'h1234;
        wait_valid("fwd", 1'b0);
        chk("fwd.Ain_old", bus.Ain, 16'h0000);
        do_ack("fwd");
        set_fetch(3'd3, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0000);
        wait_valid("fwd2", 1'b0);
        chk("fwd2.Ain_new", bus.Ain, 16'h1234);
        do_ack("fwd2");

        wr(3'd1, 16'hF0CF);
        wr(3'd2, 16'hB965);
        wr(3'd4, 16'h8001);
        wr(3'd5, 16'h7FFF);

        // table-driven operand fetches
        for (int i = 0; i < 10; i++) begin
            set_fetch(vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].asel, vecs[i].bsel, vecs[i].imm);
            wait_valid($sformatf("v%0d", i), 1'b0);
            chk($sformatf("v%0d.Ain", i), bus.Ain, vecs[i].exp_ain);
            chk($sformatf("v%0d.Bin", i), bus.Bin, vecs[i].exp_bin);
            chk($sformatf("v%0d.busy", i), {15'd0, bus.busy}, 16'd1);
            do_ack($sformatf("v%0d", i));
        end

        // hold ack low for 5 cycles: outputs stable and valid; write mid-hold
        set_fetch(3'd1, 3'd2, 2'b00, 1'b1, 1'b1, 16'hFFF0);
        wait_valid("hold", 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.write = (k == 2); bus.writenum = 3'd2; bus.data_in = 16'hB965;
            @(negedge clk);
            bus.write = 1'b0;
            chk($sformatf("hold%0d.valid", k), {15'd0, bus.valid}, 16'd1);
            chk($sformatf("hold%0d.Ain", k), bus.Ain, 16'h0000);
            chk($sformatf("hold%0d.Bin", k), bus.Bin, 16'hFFF0);
        end
        do_ack("hold");

        // ack outside ISSUE is ignored: fetch still completes with valid held
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        set_fetch(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        bus.start = 1'b0;
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ackign.valid", {15'd0, bus.valid}, 16'd1);
        chk("ackign.Bin", bus.Bin, 16'hB965);
        do_ack("ackign");

        // start pulsed in LOAD_A and in ISSUE is not queued
        set_fetch(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000);
        wait_valid("noq", 1'b1);
        bus.start = 1'b1;
        do_ack("noq");
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("noq%0d.busy", k), {15'd0, bus.busy}, 16'd0);
        end

        // reset in LOAD_B aborts immediately and clears the register file
        set_fetch(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("rlb.Ain_pre", bus.Ain, 16'hF0CF);
        #2;
        reset = 1'b0;
        #1;
        chk("rlb.valid", {15'd0, bus.valid}, 16'd0);
        chk("rlb.busy", {15'd0, bus.busy}, 16'd0);
        chk("rlb.Ain", bus.Ain, 16'h0000);
        chk("rlb.Bin", bus.Bin, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        set_fetch(3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0000);
        wait_valid("post", 1'b0);
        chk("post.Ain_R1", bus.Ain, 16'h0000);
        chk("post.Bin_R1", bus.Bin, 16'h0000);
        do_ack("post");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
